// File: rtl/gpio_irq_ctrl_if.sv
// Peripheral bus bundle for the GPIO controller.
// Single-cycle select/write/done handshake with combinational read data.
interface gpio_irq_ctrl_if;
    logic        ss;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;

    modport master (
        output ss, we, addr, wdata,
        input  rdata, bdone
    );

    modport slave (
        input  ss, we, addr, wdata,
        output rdata, bdone
    );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// GPIO controller: direction, atomic set/clear, level/edge interrupts.
// Optional per-pin input debounce filter enabled by GPIO_DEBOUNCE_EN.
module gpio_irq_ctrl #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gpio_irq_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] pins_o,
    output logic [WIDTH-1:0] pins_oe,
    output logic             irq
);

    localparam logic [7:0] A_DIN  = 8'h00;
    localparam logic [7:0] A_DIR  = 8'h04;
    localparam logic [7:0] A_OUT  = 8'h08;
    localparam logic [7:0] A_SET  = 8'h0C;
    localparam logic [7:0] A_CLR  = 8'h10;
    localparam logic [7:0] A_EN   = 8'h14;
    localparam logic [7:0] A_TYPE = 8'h18;
    localparam logic [7:0] A_POL  = 8'h1C;
    localparam logic [7:0] A_BOTH = 8'h20;
    localparam logic [7:0] A_STAT = 8'h24;
    localparam logic [7:0] A_DEB  = 8'h28;

    localparam logic [2:0] WARM_END =
        3'((SYNC_STAGES + 1 > 7) ? 7 : SYNC_STAGES + 1);

    logic [7:0]       a;
    logic [WIDTH-1:0] wd;
    logic             wr;
    logic             unused_bits;

    assign a           = bus.addr[7:0];
    assign wd          = bus.wdata[WIDTH-1:0];
    assign wr          = bus.ss & bus.we;
    assign unused_bits = ^{bus.addr[31:8], bus.wdata};

    logic hit_din, hit_dir, hit_out, hit_set, hit_clr, hit_en;
    logic hit_type, hit_pol, hit_both, hit_stat, hit_deb;

    assign hit_din  = (a == A_DIN);
    assign hit_dir  = (a == A_DIR);
    assign hit_out  = (a == A_OUT);
    assign hit_set  = (a == A_SET);
    assign hit_clr  = (a == A_CLR);
    assign hit_en   = (a == A_EN);
    assign hit_type = (a == A_TYPE);
    assign hit_pol  = (a == A_POL);
    assign hit_both = (a == A_BOTH);
    assign hit_stat = (a == A_STAT);
    assign hit_deb  = (a == A_DEB);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pins_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    logic [WIDTH-1:0] deb_mask;
    logic [WIDTH-1:0] din;

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0]    deb_cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // Counter only runs while the synced input disagrees with the filtered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_mask <= '0;
            filt_q   <= '0;
            for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else begin
            if (wr && hit_deb) deb_mask <= wd;
            for (int i = 0; i < WIDTH; i++) begin
                if (!deb_mask[i] || synced[i] == filt_q[i]) begin
                    deb_cnt[i] <= '0;
                    filt_q[i]  <= synced[i];
                end else if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    filt_q[i]  <= synced[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign din = (deb_mask & filt_q) | (~deb_mask & synced);
`else
    localparam int unused_deb_cycles = DEBOUNCE_CYCLES;

    assign deb_mask = '0;
    assign din      = synced;
`endif

    logic [WIDTH-1:0] dir_q, out_q, en_q, type_q, pol_q, both_q;
    logic [WIDTH-1:0] stat_q, prev_q;
    logic [2:0]       warm_q;
    logic             warm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) warm_q <= '0;
        else if (warm_q != WARM_END) warm_q <= warm_q + 3'd1;
    end

    assign warm_done = (warm_q == WARM_END);

    logic [WIDTH-1:0] rise, fall, edge_ev, lvl_ev, ev, w1c;

    assign rise    = din & ~prev_q;
    assign fall    = ~din & prev_q;
    assign edge_ev = (both_q & (rise | fall))
                   | (~both_q & pol_q & rise)
                   | (~both_q & ~pol_q & fall);
    assign lvl_ev  = ~type_q & ~(din ^ pol_q);
    assign ev      = lvl_ev | (type_q & edge_ev & {WIDTH{warm_done}});
    assign w1c     = (wr && hit_stat) ? wd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q  <= '0;
            out_q  <= '0;
            en_q   <= '0;
            type_q <= '0;
            pol_q  <= '0;
            both_q <= '0;
            stat_q <= '0;
            prev_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && hit_dir)  dir_q  <= wd;
            if (wr && hit_en)   en_q   <= wd;
            if (wr && hit_type) type_q <= wd;
            if (wr && hit_pol)  pol_q  <= wd;
            if (wr && hit_both) both_q <= wd;
            if (wr) begin
                unique case (1'b1)
                    hit_out: out_q <= wd;
                    hit_set: out_q <= out_q | wd;
                    hit_clr: out_q <= out_q & ~wd;
                    default: ;
                endcase
            end
            // A new event wins over a same-cycle clear.
            stat_q <= (stat_q & ~w1c) | ev;
            prev_q <= din;
            irq    <= |(stat_q & en_q);
        end
    end

    logic [31:0] rd;

    always_comb begin
        rd = '0;
        unique case (1'b1)
            hit_din:  rd = 32'(din);
            hit_dir:  rd = 32'(dir_q);
            hit_out:  rd = 32'(out_q);
            hit_en:   rd = 32'(en_q);
            hit_type: rd = 32'(type_q);
            hit_pol:  rd = 32'(pol_q);
            hit_both: rd = 32'(both_q);
            hit_stat: rd = 32'(stat_q);
            hit_deb:  rd = 32'(deb_mask);
            default:  rd = '0;
        endcase
    end

    assign bus.rdata = rd;
    assign bus.bdone = 1'b1;
    assign pins_o    = out_q;
    assign pins_oe   = dir_q;

endmodule
